// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Holds the md_op codes, the FSM state encodings, the iteration count,
// and a small absolute-value helper used when operands are latched.
package hilo_muldiv_unit_pkg;

  localparam int MD_ITER = 32;

  // Operation codes as driven by the control-unit mapping in the core top.
  // Codes 3'd6 and 3'd7 are reserved and ignored by the unit.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } md_state_e;

  // Magnitude of a 32-bit operand. For signed ops a negative value is
  // negated; 0x80000000 negates to itself, which read as unsigned is the
  // correct magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic signed_op);
    logic [31:0] r;
    if (signed_op && v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_md_iter_step.sv
// md_iter_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   is_div    - 1 selects restoring divide, 0 selects shift-add multiply
//   acc_hi    - upper accumulator word (multiply) / partial remainder (divide)
//   low_bit   - multiply: accumulator bit 0 (current multiplier bit);
//               divide: accumulator bit 31 (next dividend bit to shift in)
//   opnd      - multiplicand magnitude / divisor magnitude
//   part_next - next upper accumulator word / next partial remainder
//   bit_out   - multiply: bit shifted into the low word; divide: quotient bit
module md_iter_step
  import hilo_muldiv_unit_pkg::*;
(
  input  logic        is_div,
  input  logic [31:0] acc_hi,
  input  logic        low_bit,
  input  logic [31:0] opnd,
  output logic [31:0] part_next,
  output logic        bit_out
);

  logic [32:0] sum;
  logic [32:0] trial;
  logic [32:0] diff;

  // Single iteration: conditional add then shift right (mul), or shift-left
  // trial subtraction with restore (div).
  always_comb begin
    sum   = {1'b0, acc_hi} + (low_bit ? {1'b0, opnd} : 33'd0);
    trial = {acc_hi, low_bit};
    // Remainder stays below the divisor, so trial < 2*divisor and bit 32 of
    // the difference is a clean borrow flag.
    diff  = trial - {1'b0, opnd};
    if (is_div) begin
      if (!diff[32]) begin
        part_next = diff[31:0];
        bit_out   = 1'b1;
      end else begin
        part_next = trial[31:0];
        bit_out   = 1'b0;
      end
    end else begin
      part_next = sum[32:1];
      bit_out   = sum[0];
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative 32-cycle multiply / restoring divide owning HI/LO.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   md_start, md_op   - request strobe and operation code (sampled in IDLE only)
//   rs_data, rt_data  - multiplicand/dividend/MTxx source, multiplier/divisor
//   busy              - high for the 33 cycles a mul/div is in flight
//   hi, lo            - HI/LO architectural registers
//   div_zero          - one-cycle pulse after an accepted divide by zero
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = MD_ITER
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_zero
);

  md_state_e   state, next_state;
  logic [4:0]  cnt, next_cnt;
  logic [63:0] acc, next_acc;
  logic [31:0] opnd, next_opnd;
  logic        is_div, next_is_div;
  logic        neg_res, next_neg_res;
  logic        neg_rem, next_neg_rem;
  logic [31:0] next_hi, next_lo;
  logic        next_div_zero;

  logic        op_signed;
  logic        step_low_bit;
  logic [31:0] step_part;
  logic        step_bit;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign step_low_bit = is_div ? acc[31] : acc[0];

  md_iter_step u_step (
    .is_div    (is_div),
    .acc_hi    (acc[63:32]),
    .low_bit   (step_low_bit),
    .opnd      (opnd),
    .part_next (step_part),
    .bit_out   (step_bit)
  );

  // Next-state and next-register logic for the IDLE/RUN/FINISH sequencer.
  always_comb begin
    next_state    = state;
    next_cnt      = cnt;
    next_acc      = acc;
    next_opnd     = opnd;
    next_is_div   = is_div;
    next_neg_res  = neg_res;
    next_neg_rem  = neg_rem;
    next_hi       = hi;
    next_lo       = lo;
    next_div_zero = 1'b0;
    op_signed     = (md_op == MD_MULT) || (md_op == MD_DIV);
    prod_fix      = neg_res ? (64'd0 - acc) : acc;
    quot_fix      = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix       = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];

    case (state)
      ST_IDLE: begin
        if (md_start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              next_acc     = {32'd0, abs32(rt_data, op_signed)};
              next_opnd    = abs32(rs_data, op_signed);
              next_is_div  = 1'b0;
              next_neg_res = op_signed && (rs_data[31] ^ rt_data[31]);
              next_neg_rem = 1'b0;
              next_cnt     = 5'd0;
              next_state   = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              if (rt_data == 32'd0) begin
                // Divide by zero resolves immediately, no iterations.
                next_hi       = rs_data;
                next_lo       = 32'hFFFF_FFFF;
                next_div_zero = 1'b1;
              end else begin
                next_acc     = {32'd0, abs32(rs_data, op_signed)};
                next_opnd    = abs32(rt_data, op_signed);
                next_is_div  = 1'b1;
                next_neg_res = op_signed && (rs_data[31] ^ rt_data[31]);
                next_neg_rem = op_signed && rs_data[31];
                next_cnt     = 5'd0;
                next_state   = ST_RUN;
              end
            end
            MD_MTHI: next_hi = rs_data;
            MD_MTLO: next_lo = rs_data;
            default: ;  // reserved codes: stay idle, no change
          endcase
        end else begin
          next_state = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (is_div) begin
          next_acc = {step_part, acc[30:0], step_bit};
        end else begin
          next_acc = {step_part, step_bit, acc[31:1]};
        end
        next_cnt = cnt + 5'd1;
        if (cnt == 5'(ITER - 1)) begin
          next_state = ST_FINISH;
        end else begin
          next_state = ST_RUN;
        end
      end

      ST_FINISH: begin
        if (is_div) begin
          next_hi = rem_fix;
          next_lo = quot_fix;
        end else begin
          next_hi = prod_fix[63:32];
          next_lo = prod_fix[31:0];
        end
        next_state = ST_IDLE;
      end

      default: next_state = ST_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      acc      <= next_acc;
      opnd     <= next_opnd;
      is_div   <= next_is_div;
      neg_res  <= next_neg_res;
      neg_rem  <= next_neg_rem;
      hi       <= next_hi;
      lo       <= next_lo;
      busy     <= (next_state != ST_IDLE);
      div_zero <= next_div_zero;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: a reference model computes
// expected HI/LO when a request is issued; the entry is queued and compared
// once the unit reports completion.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] hilo;
    int          busy_cycles;
    logic        dz;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [63:0] model_hilo;

  hilo_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start),
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: builtin 64-bit arithmetic, with the unit's divide-by-zero rule.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    longint      sa, sb, q, m;
    logic [63:0] r, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: r = ua * ub;
      3'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      3'd4: r = {a, prev[31:0]};
      3'd5: r = {prev[63:32], a};
      default: r = prev;
    endcase
    return r;
  endfunction

  // Drive one request for a single cycle; returns at the negedge after it.
  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op    = op;
    rs_data  = a;
    rt_data  = b;
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    sb_entry_t e;
    e.tag  = tag;
    e.hilo = model(op, a, b, model_hilo);
    e.dz   = (op == 3'd2 || op == 3'd3) && (b == 32'd0);
    e.busy_cycles = (op <= 3'd3 && !e.dz) ? 33 : 0;
    model_hilo = e.hilo;
    sb_q.push_back(e);
    pulse(op, a, b);
  endtask

  // Wait (bounded) for busy to drop, then compare against the queue head.
  // already: busy cycles that elapsed before this call.
  task automatic collect(input int already);
    sb_entry_t e;
    int n;
    n = already;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (sb_q.size() == 0) begin
      check_value("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_value({e.tag, "_busy_cycles"}, 64'(n), 64'(e.busy_cycles));
      check_value({e.tag, "_hi"}, {32'd0, hi}, {32'd0, e.hilo[63:32]});
      check_value({e.tag, "_lo"}, {32'd0, lo}, {32'd0, e.hilo[31:0]});
      check_value({e.tag, "_div_zero"}, {63'd0, div_zero}, {63'd0, e.dz});
      if (e.dz) begin
        @(negedge clk);
        check_value({e.tag, "_div_zero_gone"}, {63'd0, div_zero}, 64'd0);
        check_value({e.tag, "_busy_after"}, {63'd0, busy}, 64'd0);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    md_start   = 1'b0;
    md_op      = 3'd0;
    rs_data    = 32'd0;
    rt_data    = 32'd0;
    model_hilo = 64'd0;
    repeat (2) @(negedge clk);
    check_value("reset_busy", {63'd0, busy}, 64'd0);
    check_value("reset_hilo", {hi, lo}, 64'd0);
    check_value("reset_div_zero", {63'd0, div_zero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");  collect(0);
    check_value("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");        collect(0);
    check_value("mult_neg3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");        collect(0);
    check_value("div_neg7by2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd3, 32'd7, 32'd2, "divu_7by2_b2b");              collect(0);
    check_value("divu_7by2_const", {hi, lo}, 64'h0000_0001_0000_0003);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_minint"); collect(0);
    check_value("div_minint_const", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(3'd3, 32'd5, 32'd0, "divu_by_zero");               collect(0);
    issue(3'd2, 32'hFFFF_FF00, 32'd0, "div_by_zero");        collect(0);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minint"); collect(0);

    // MTHI while a multiply runs must be ignored.
    issue(3'd0, 32'd100, 32'hFFFF_FFFE, "mult_vs_mthi");
    repeat (3) @(negedge clk);
    pulse(3'd4, 32'h0000_1234, 32'd0);
    collect(4);

    issue(3'd5, 32'h0000_ABCD, 32'd0, "mtlo");     collect(0);
    issue(3'd4, 32'h5555_AAAA, 32'd0, "mthi");     collect(0);
    issue(3'd6, 32'hDEAD_BEEF, 32'd1, "reserved6"); collect(0);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1, "reserved7"); collect(0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      if (i % 3 == 0) a = -a;
      issue(op, a, b, "random_op");
      collect(0);
    end

    // Reset in the middle of a multiply aborts with HI/LO cleared.
    pulse(3'd0, 32'h1234_5678, 32'h0000_5678);
    repeat (9) @(negedge clk);
    check_value("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_value("mid_reset_busy", {63'd0, busy}, 64'd0);
    check_value("mid_reset_hilo", {hi, lo}, 64'd0);
    model_hilo = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_value("post_reset_idle_hilo", {hi, lo}, 64'd0);
    issue(3'd1, 32'd6, 32'd7, "after_reset_multu"); collect(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
